// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle controller for the 32-bit shift path. One request is accepted
// at a time. The fixed-distance stages 16, 8, 4, 2 and 1 are applied to a
// single working register, one stage per clock. Completion is signalled by
// a one-cycle done pulse.
//
// Parameters
//   EARLY_EXIT : 1 = finish as soon as the remaining lower shamt bits are zero
//
// Ports
//   clock     in   1   single clock, rising edge
//   reset_n   in   1   asynchronous active-low reset
//   start     in   1   request, sampled only while ready=1
//   lr_shift  in   1   0 = left logical, 1 = right arithmetic
//   shamt     in   5   shift amount 0..31
//   operand   in  32   value to shift
//   result    out 32   shifted value, valid from done until next accept
//   ready     out  1   able to accept start (IDLE, DONE)
//   busy      out  1   operation in progress (SHIFT)
//   done      out  1   one-cycle completion pulse (DONE)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// SHIFT | applying stage r_k (4..0), r_k counts down
// DONE  | result valid, done pulse; a new start is accepted here
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        lr_shift,
  input  logic [4:0]  shamt,
  input  logic [31:0] operand,
  output logic [31:0] result,
  output logic        ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_work;
  logic        r_lr;
  logic [4:0]  r_shamt;
  logic [2:0]  r_k;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_stage_en;
  logic        w_lower_zero;
  logic        w_last;
  logic [31:0] w_shl;
  logic [31:0] w_sra;
  logic [31:0] w_work_nxt;

  // Requests are only taken in the states that advertise ready.
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  // Per-stage decode. The right-shift fill uses the working register's MSB,
  // which stays equal to the original operand's sign through every stage.
  always_comb begin
    w_stage_en   = 1'b0;
    w_lower_zero = 1'b1;
    w_shl        = r_work;
    w_sra        = r_work;
    case (r_k)
      3'd4: begin
        w_stage_en   = r_shamt[4];
        w_lower_zero = (r_shamt[3:0] == 4'd0);
        w_shl        = {r_work[15:0], 16'h0000};
        w_sra        = {{16{r_work[31]}}, r_work[31:16]};
      end
      3'd3: begin
        w_stage_en   = r_shamt[3];
        w_lower_zero = (r_shamt[2:0] == 3'd0);
        w_shl        = {r_work[23:0], 8'h00};
        w_sra        = {{8{r_work[31]}}, r_work[31:8]};
      end
      3'd2: begin
        w_stage_en   = r_shamt[2];
        w_lower_zero = (r_shamt[1:0] == 2'd0);
        w_shl        = {r_work[27:0], 4'h0};
        w_sra        = {{4{r_work[31]}}, r_work[31:4]};
      end
      3'd1: begin
        w_stage_en   = r_shamt[1];
        w_lower_zero = (r_shamt[0] == 1'b0);
        w_shl        = {r_work[29:0], 2'b00};
        w_sra        = {{2{r_work[31]}}, r_work[31:2]};
      end
      3'd0: begin
        w_stage_en   = r_shamt[0];
        w_lower_zero = 1'b1;
        w_shl        = {r_work[30:0], 1'b0};
        w_sra        = {r_work[31], r_work[31:1]};
      end
      default: begin
        w_stage_en   = 1'b0;
        w_lower_zero = 1'b1;
        w_shl        = r_work;
        w_sra        = r_work;
      end
    endcase
  end

  assign w_work_nxt = w_stage_en ? (r_lr ? w_sra : w_shl) : r_work;

  // Final stage: k reached 0, or (early exit) nothing left to shift below k.
  assign w_last = (r_k == 3'd0) || (EARLY_EXIT && w_lower_zero);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = w_accept ? SHIFT : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (state register only, no input-to-output path)
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      IDLE:  ready = 1'b1;
      SHIFT: busy  = 1'b1;
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operands latched at accept, one stage per SHIFT cycle.
  // r_k is a down-counter over the stage index.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_work   <= 32'h0000_0000;
      r_lr     <= 1'b0;
      r_shamt  <= 5'd0;
      r_k      <= 3'd0;
      r_result <= 32'h0000_0000;
    end else if (w_accept) begin
      r_work  <= operand;
      r_lr    <= lr_shift;
      r_shamt <= shamt;
      r_k     <= 3'd4;
    end else if (r_state == SHIFT) begin
      r_work <= w_work_nxt;
      if (w_last) begin
        r_result <= w_work_nxt;
      end else begin
        r_k <= r_k - 3'd1;
      end
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clock;
  logic        reset_n;
  logic [1:0]  start_v;
  logic [1:0]  lr_v;
  logic [1:0]  ready_v;
  logic [1:0]  busy_v;
  logic [1:0]  done_v;
  logic [4:0]  shamt_v   [2];
  logic [31:0] operand_v [2];
  logic [31:0] result_v  [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  typedef struct {
    bit          ee;
    bit          lr;
    logic [4:0]  sh;
    logic [31:0] op;
    logic [31:0] exp;
    int          lat;
    bit          b2b;
  } vec_t;

  vec_t vecs [16];

  shift_sequencer #(.EARLY_EXIT(1'b0)) u_dut0 (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start_v[0]),
    .lr_shift (lr_v[0]),
    .shamt    (shamt_v[0]),
    .operand  (operand_v[0]),
    .result   (result_v[0]),
    .ready    (ready_v[0]),
    .busy     (busy_v[0]),
    .done     (done_v[0])
  );

  shift_sequencer #(.EARLY_EXIT(1'b1)) u_dut1 (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start_v[1]),
    .lr_shift (lr_v[1]),
    .shamt    (shamt_v[1]),
    .operand  (operand_v[1]),
    .result   (result_v[1]),
    .ready    (ready_v[1]),
    .busy     (busy_v[1]),
    .done     (done_v[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboards: every done pulse pops the oldest expected result.
  always @(negedge clock) begin
    if (reset_n && done_v[0]) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected_done: got done=1 expected no done, result 0x%08h", result_v[0]);
      end else begin
        check("dut0_result", result_v[0], q0.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && done_v[1]) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_done: got done=1 expected no done, result 0x%08h", result_v[1]);
      end else begin
        check("dut1_result", result_v[1], q1.pop_front());
      end
    end
  end

  // Drives one request at the next falling edge, then follows it to done,
  // checking handshake outputs every cycle and the latency from accept.
  task automatic run_op(input bit ee, input bit lr, input logic [4:0] sh,
                        input logic [31:0] op, input logic [31:0] exp,
                        input int lat, input string name);
    int idx;
    int cycles;
    bit got;
    idx = ee ? 1 : 0;
    @(negedge clock);
    lr_v[idx]      = lr;
    shamt_v[idx]   = sh;
    operand_v[idx] = op;
    start_v[idx]   = 1'b1;
    if (idx == 0) q0.push_back(exp);
    else          q1.push_back(exp);
    @(posedge clock);
    #1;
    start_v[idx]   = 1'b0;
    // Scramble inputs: the in-flight operation must use the latched copies.
    operand_v[idx] = $urandom;
    shamt_v[idx]   = 5'($urandom_range(0, 31));
    lr_v[idx]      = ~lr;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 12) begin
      if (done_v[idx]) begin
        got = 1'b1;
      end else begin
        check({name, "_busy"},  32'(busy_v[idx]),  32'd1);
        check({name, "_ready"}, 32'(ready_v[idx]), 32'd0);
        @(posedge clock);
        #1;
        cycles++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done at %0d", name, cycles, lat);
    end else begin
      check({name, "_latency"},    32'(cycles),         32'(lat));
      check({name, "_done_ready"}, 32'(ready_v[idx]),   32'd1);
      check({name, "_done_busy"},  32'(busy_v[idx]),    32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int first_done;

    vecs[0]  = '{1'b0, 1'b0, 5'd31, 32'h0000_0001, 32'h8000_0000, 5, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 5'd4,  32'h8000_0000, 32'hF800_0000, 5, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 5'd16, 32'h7FFF_FFFF, 32'h0000_7FFF, 5, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 5, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 5'd5,  32'h0000_00FF, 32'h0000_1FE0, 5, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000, 5, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 5'd16, 32'h1234_5678, 32'h5678_0000, 1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  32'h1234_5678, 32'h1234_5678, 1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 5'd31, 32'h0000_0001, 32'h8000_0000, 5, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 5'd8,  32'h8000_0000, 32'hFF80_0000, 2, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 5'd4,  32'h4000_0000, 32'h0400_0000, 3, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 5'd24, 32'h0000_00AB, 32'hAB00_0000, 2, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 5'd1,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 5, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 5'd2,  32'h0000_0003, 32'h0000_000C, 4, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 5'd16, 32'h8000_0000, 32'hFFFF_8000, 1, 1'b1};

    reset_n = 1'b0;
    start_v = 2'b00;
    lr_v    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      shamt_v[i]   = 5'd0;
      operand_v[i] = 32'h0;
    end

    #12;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_result%0d", i), result_v[i],      32'h0);
      check($sformatf("reset_ready%0d", i),  32'(ready_v[i]),  32'd1);
      check($sformatf("reset_busy%0d", i),   32'(busy_v[i]),   32'd0);
      check($sformatf("reset_done%0d", i),   32'(done_v[i]),   32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 16; i++) begin
      if (!vecs[i].b2b) repeat (2) @(posedge clock);
      run_op(vecs[i].ee, vecs[i].lr, vecs[i].sh, vecs[i].op, vecs[i].exp,
             vecs[i].lat, $sformatf("vec%0d", i));
    end

    // start pulsed mid-operation must be ignored
    repeat (3) @(posedge clock);
    @(negedge clock);
    lr_v[0] = 1'b1; shamt_v[0] = 5'd8; operand_v[0] = 32'hFFFF_0000; start_v[0] = 1'b1;
    q0.push_back(32'hFFFF_FF00);
    @(posedge clock);               // E0
    #1 start_v[0] = 1'b0;
    @(posedge clock);               // E1
    @(negedge clock);
    lr_v[0] = 1'b0; shamt_v[0] = 5'd3; operand_v[0] = 32'hDEAD_BEEF; start_v[0] = 1'b1;
    @(posedge clock);               // E2
    #1 start_v[0] = 1'b0;
    dones = 0;
    first_done = -1;
    for (int c = 3; c <= 14; c++) begin
      @(posedge clock);
      #1;
      if (done_v[0]) begin
        dones++;
        if (first_done < 0) first_done = c;
      end
    end
    check("ignored_start_done_count", 32'(dones), 32'd1);
    check("ignored_start_done_edge",  32'(first_done), 32'd5);
    check("ignored_start_result", result_v[0], 32'hFFFF_FF00);

    // reset between E2 and E3 aborts the operation
    @(negedge clock);
    lr_v[0] = 1'b1; shamt_v[0] = 5'd8; operand_v[0] = 32'hFFFF_0000; start_v[0] = 1'b1;
    @(posedge clock);               // E0
    #1 start_v[0] = 1'b0;
    @(posedge clock);               // E1
    @(posedge clock);               // E2
    #3 reset_n = 1'b0;
    #1;
    check("abort_result", result_v[0],     32'h0);
    check("abort_busy",   32'(busy_v[0]),  32'd0);
    check("abort_done",   32'(done_v[0]),  32'd0);
    check("abort_ready",  32'(ready_v[0]), 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      if (done_v[0]) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op(1'b0, 1'b0, 5'd1, 32'h0000_0001, 32'h0000_0002, 5, "post_reset");

    repeat (3) @(posedge clock);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
